aes_inv_cipher_top: RTL and testbench

AES-128 decryption core; the inverse of the existing iterative cipher. It runs one round per clock, using InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns.
Round keys must be used in reverse order, so a key-load phase first runs the forward key expander (aes_key_expand_128) and stores all 11 round keys in an internal buffer. Decryptions then reuse the buffered keys until a new key is loaded.
The block sits beside the cipher top in the crypto datapath.

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/aes_inv_sbox.sv | 28 ++
 rtl/aes_key_expand_128.sv | 59 +++++
 rtl/aes_inv_cipher_top.sv | 121 ++++++++++++
 tb/tb_aes_inv_cipher_top.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) column/row helpers used by the cipher and inverse cipher tops.
// State is column-major: s[c][r], with s[0][0] occupying bits [127:120].
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [7:0]              byte_t;
    typedef logic [31:0]             word_t;
    typedef logic [0:3][0:3][7:0]    state_t;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t mix_col(input word_t w);
        byte_t a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Multiples 9, b, d, e are assembled from the x2/x4/x8 xtime chain.
    function automatic word_t inv_mix_col(input word_t w);
        byte_t a, x2, x4, x8;
        byte_t m9 [4];
        byte_t mb [4];
        byte_t md [4];
        byte_t me [4];
        for (int i = 0; i < 4; i++) begin
            a     = w[31-8*i -: 8];
            x2    = xtime(a);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[c][r] = s[(c - r + 4) % 4][r];
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box; table is packed with entry 0 in the top byte.
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] d
);

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign d = INV_SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand_128.sv
// AES-128 forward key expander: loads the cipher key on kld, then steps one round key per clock.
// w0..w3 hold rk0 in the cycle after kld and rk_i i cycles later.
module aes_key_expand_128
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         kld,
    input  logic [127:0] key,
    output logic [31:0]  w0,
    output logic [31:0]  w1,
    output logic [31:0]  w2,
    output logic [31:0]  w3
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    byte_t rc;
    word_t rot, sub, n0, n1, n2, n3;

    always_comb begin
        rot = {w3[23:0], w3[31:24]};
        sub = '0;
        for (int i = 0; i < 4; i++)
            sub[31-8*i -: 8] = SBOX[{~rot[31-8*i -: 8], 3'b000} +: 8];
        n0 = w0 ^ sub ^ {rc, 24'h000000};
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
    end

    // rcon doubles in GF(2^8) each round; it keeps running harmlessly past rk10.
    always_ff @(posedge clk) begin
        if (kld) begin
            {w0, w1, w2, w3} <= key;
            rc               <= 8'h01;
        end else begin
            {w0, w1, w2, w3} <= {n0, n1, n2, n3};
            rc               <= xtime(rc);
        end
    end

endmodule

// File: rtl/aes_inv_cipher_top.sv
// Iterative AES-128 decryptor: buffers all round keys on kld, then runs one inverse round per clock.
module aes_inv_cipher_top
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    output logic         kdone,
    output logic         ready,
    input  logic         ld,
    input  logic [127:0] text_in,
    output logic         done,
    output logic [127:0] text_out
);

    if (NR != AES_NR) begin : g_nr_check
        $error("aes_inv_cipher_top supports only NR=10");
    end

    logic [31:0]  w0, w1, w2, w3;
    logic [127:0] kb [0:NR];
    logic         kbusy, key_valid, dbusy;
    logic [3:0]   kcnt, dcnt, kidx;
    logic [127:0] text_in_r;
    logic [127:0] isr_v;
    wire  [127:0] isb_v;
    state_t       state, ark, imc;

    aes_key_expand_128 u_kexp (
        .clk (clk),
        .kld (kld),
        .key (key),
        .w0  (w0),
        .w1  (w1),
        .w2  (w2),
        .w3  (w3)
    );

    assign ready = key_valid & ~dbusy;

    // dcnt counts 11 down to 1; round key index tracks it one behind.
    assign kidx  = (dcnt == 4'd0) ? 4'd0 : dcnt - 4'd1;
    assign isr_v = inv_shift_rows(state);

    for (genvar i = 0; i < 16; i++) begin : g_isb
        aes_inv_sbox u_isb (
            .a (isr_v[127-8*i -: 8]),
            .d (isb_v[127-8*i -: 8])
        );
    end

    always_comb begin
        ark = isb_v ^ kb[kidx];
        imc = ark;
        for (int c = 0; c < 4; c++)
            imc[c] = inv_mix_col(ark[c]);
    end

    always_ff @(posedge clk) begin
        if (kbusy && !kld)
            kb[kcnt] <= {w0, w1, w2, w3};
    end

    always_ff @(posedge clk) begin
        if (ld && ready && !kld)
            text_in_r <= text_in;
    end

    // kld wins over everything: it restarts key buffering and abandons any decrypt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kbusy     <= 1'b0;
            key_valid <= 1'b0;
            kcnt      <= 4'd0;
            kdone     <= 1'b0;
            dbusy     <= 1'b0;
            dcnt      <= 4'd0;
            done      <= 1'b0;
            state     <= '0;
            text_out  <= '0;
        end else begin
            kdone <= 1'b0;
            done  <= 1'b0;
            if (kld) begin
                kbusy     <= 1'b1;
                kcnt      <= 4'd0;
                key_valid <= 1'b0;
                dbusy     <= 1'b0;
                dcnt      <= 4'd0;
            end else begin
                if (kbusy) begin
                    kcnt <= kcnt + 4'd1;
                    if (kcnt == 4'(NR)) begin
                        kbusy     <= 1'b0;
                        key_valid <= 1'b1;
                        kdone     <= 1'b1;
                    end
                end
                if (dbusy) begin
                    dcnt <= dcnt - 4'd1;
                    if (dcnt == 4'(NR + 1)) begin
                        state <= text_in_r ^ kb[kidx];
                    end else if (dcnt == 4'd1) begin
                        text_out <= ark;
                        done     <= 1'b1;
                        dbusy    <= 1'b0;
                    end else begin
                        state <= imc;
                    end
                end else if (ld && ready) begin
                    dbusy <= 1'b1;
                    dcnt  <= 4'(NR + 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// Bench for aes_inv_cipher_top: textbook AES model (S-box derived from GF inverse + affine map)
// drives a per-cycle expectation of kdone/done/ready/text_out, plus FIPS-197 literal vectors.
module tb_aes_inv_cipher_top;

    logic         clk = 1'b0;
    logic         rst;
    logic         kld, ld;
    logic [127:0] key, text_in;
    logic         kdone, ready, done;
    logic [127:0] text_out;

    aes_inv_cipher_top dut (
        .clk      (clk),
        .rst      (rst),
        .kld      (kld),
        .key      (key),
        .kdone    (kdone),
        .ready    (ready),
        .ld       (ld),
        .text_in  (text_in),
        .done     (done),
        .text_out (text_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] x, input int i);
        return x[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] rk_of(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3, c0, c1, c2, c3;
        c0 = inv ? 8'h0e : 8'h02; c1 = inv ? 8'h0b : 8'h03;
        c2 = inv ? 8'h0d : 8'h01; c3 = inv ? 8'h09 : 8'h01;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            o[127-32*c -: 8]  = gmul(c0, a0) ^ gmul(c1, a1) ^ gmul(c2, a2) ^ gmul(c3, a3);
            o[119-32*c -: 8]  = gmul(c3, a0) ^ gmul(c0, a1) ^ gmul(c1, a2) ^ gmul(c2, a3);
            o[111-32*c -: 8]  = gmul(c2, a0) ^ gmul(c3, a1) ^ gmul(c0, a2) ^ gmul(c1, a3);
            o[103-32*c -: 8]  = gmul(c1, a0) ^ gmul(c2, a1) ^ gmul(c3, a2) ^ gmul(c0, a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [127:0] s, t;
        s = pt ^ rk_of(k, 0);
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++)
                t[127-8*i -: 8] = sb[gb(s, (i % 4) + 4 * (((i / 4) + (i % 4)) % 4))];
            if (rnd < 10) t = mix(t, 1'b0);
            s = t ^ rk_of(k, rnd);
        end
        return s;
    endfunction

    function automatic logic [127:0] model_dec(input logic [127:0] k, input logic [127:0] ct);
        logic [127:0] s, t;
        s = ct ^ rk_of(k, 10);
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int i = 0; i < 16; i++)
                t[127-8*i -: 8] = isb[gb(s, (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4))];
            s = t ^ rk_of(k, rnd);
            if (rnd > 0) s = mix(s, 1'b1);
        end
        return s;
    endfunction

    // ---------------- transaction-level timing model ----------------
    bit           key_loaded = 0;
    int           kdone_edge = -1;
    int           done_edge  = -1;
    logic [127:0] cur_key    = '0;
    logic [127:0] exp_pt     = '0;
    logic [127:0] model_out  = '0;

    function automatic bit model_ready(input int e);
        return key_loaded && (kdone_edge < e) && (done_edge < e);
    endfunction

    always @(negedge clk) begin
        if (done_edge == cyc) model_out = exp_pt;
        chk("kdone", kdone, (kdone_edge == cyc));
        chk("done", done, (done_edge == cyc));
        chk("ready", ready, model_ready(cyc + 1));
        chk("text_out", text_out, model_out);
    end

    task automatic step(input logic k, input logic [127:0] kv, input logic l, input logic [127:0] tv);
        int e;
        bit acc;
        e   = cyc + 1;
        acc = !k && l && model_ready(e);
        kld = k; key = kv; ld = l; text_in = tv;
        @(posedge clk); #1;
        kld = 1'b0; ld = 1'b0;
        if (k) begin
            key_loaded = 1; cur_key = kv; kdone_edge = e + 11; done_edge = -1;
        end else if (acc) begin
            done_edge = e + 11; exp_pt = model_dec(cur_key, tv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, '0);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_kdone", kdone, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", ready, 0);
        chk("rst_text_out", text_out, 0);
        key_loaded = 0; kdone_edge = -1; done_edge = -1; model_out = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        logic [7:0]   inv;
        logic [127:0] rkey, pt, ct;
        rst = 1'b1; kld = 1'b0; ld = 1'b0; key = '0; text_in = '0;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = x[7:0];

        chk("m_gmul", gmul(8'h57, 8'h83), 8'hc1);
        chk("m_sbox00", sb[0], 8'h63);
        chk("m_sbox53", sb[8'h53], 8'hed);
        chk("m_rk10", rk_of(KB, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("m_enc_c1", model_enc(K1, PT1), CT1);
        chk("m_dec_b", model_dec(KB, CTB), PTB);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", ready, 0);
        chk("reset_text_out", text_out, 0);
        rst = 1'b0;

        // C.1 key load with a stray ld during the key phase
        step(1'b1, K1, 1'b0, '0);
        idle(2);
        step(1'b0, '0, 1'b1, CT1);
        idle(8);
        chk("c1_kdone", kdone, 1);

        // C.1 decrypt, stray ld at T+5, back-to-back App.B ciphertext on the done cycle
        step(1'b0, '0, 1'b1, CT1);
        idle(4);
        step(1'b0, '0, 1'b1, CTB);
        idle(6);
        chk("c1_done", done, 1);
        chk("c1_pt", text_out, PT1);
        step(1'b0, '0, 1'b1, CTB);
        idle(10);
        chk("b2b_not_yet", done, 0);
        idle(1);
        chk("b2b_done", done, 1);
        chk("b2b_pt", text_out, model_dec(K1, CTB));

        // kld at T+5 aborts the decrypt
        step(1'b0, '0, 1'b1, CT1);
        idle(4);
        step(1'b1, K1, 1'b0, '0);
        idle(11);
        chk("abort_kdone", kdone, 1);
        chk("abort_hold", text_out, model_dec(K1, CTB));

        // FIPS-197 App.B
        step(1'b1, KB, 1'b0, '0);
        idle(11);
        step(1'b0, '0, 1'b1, CTB);
        idle(11);
        chk("appb_done", done, 1);
        chk("appb_pt", text_out, PTB);

        // asynchronous reset at T+6, then ld without a key is ignored
        step(1'b0, '0, 1'b1, CTB);
        idle(6);
        async_reset();
        step(1'b0, '0, 1'b1, CTB);
        idle(12);
        chk("postrst_ready", ready, 0);
        chk("postrst_out", text_out, 0);
        step(1'b1, KB, 1'b0, '0);
        idle(11);
        step(1'b0, '0, 1'b1, CTB);
        idle(11);
        chk("postrst_pt", text_out, PTB);

        // round trip through the model's forward cipher
        for (int n = 0; n < 1000; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            pt   = {$urandom, $urandom, $urandom, $urandom};
            ct   = model_enc(rkey, pt);
            step(1'b1, rkey, 1'b0, '0);
            idle(11);
            step(1'b0, '0, 1'b1, ct);
            idle(11);
            chk("roundtrip", text_out, pt);
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
